// File: rtl/vn_lut_pkg.sv
// Shared definitions for the symmetric VN rank LUT write path.
package vn_lut_pkg;
  localparam int QUAN_SIZE   = 4;
  localparam int PAGE_ADDR_W = 6;
  localparam int ADDR_W      = 7;
  localparam int LEN_W       = ADDR_W + 1;
  localparam int LUT_DEPTH   = 128;

  typedef enum logic [1:0] {IDLE, LOAD, DONE} lut_ld_state_e;

  typedef struct packed {
    logic [QUAN_SIZE-1:0] bank1;
    logic [QUAN_SIZE-1:0] bank0;
  } entry_pair_t;

  // Lengths above the LUT depth are illegal; clamp them to a full load.
  function automatic logic [LEN_W-1:0] sat_len(input logic [LEN_W-1:0] len);
    if (len > LEN_W'(LUT_DEPTH)) return LEN_W'(LUT_DEPTH);
    return len;
  endfunction
endpackage

// File: rtl/sym_vn_lut_addr_cnt.sv
// Wrapping 7-bit write address counter plus remaining-beats down-counter.
module sym_vn_lut_addr_cnt
  import vn_lut_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic [ADDR_W-1:0] i_start_addr,
  input  logic [LEN_W-1:0]  i_len,
  input  logic              i_inc,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_last
);
  logic [ADDR_W-1:0] r_addr;
  logic [LEN_W-1:0]  r_rem;

  // Load on start, then step address (mod 128) and count down per beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr <= '0;
      r_rem  <= '0;
    end else if (i_load) begin
      r_addr <= i_start_addr;
      r_rem  <= sat_len(i_len);
    end else if (i_inc) begin
      r_addr <= r_addr + 1'b1;
      r_rem  <= r_rem - 1'b1;
    end
  end

  assign o_addr = r_addr;
  assign o_last = (r_rem == LEN_W'(1));
endmodule

// File: rtl/sym_vn_lut_loader.sv
// Write-side sequencer: turns accepted entry-pair beats into LUT writes.
module sym_vn_lut_loader
  import vn_lut_pkg::*;
(
  input  logic                   write_clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [ADDR_W-1:0]      cfg_start_addr,
  input  logic [ADDR_W:0]        cfg_len,
  input  logic [2*QUAN_SIZE-1:0] in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [QUAN_SIZE-1:0]   lut_in_bank0,
  output logic [QUAN_SIZE-1:0]   lut_in_bank1,
  output logic [PAGE_ADDR_W-1:0] page_write_addr,
  output logic                   write_addr_offset,
  output logic                   we,
  output logic                   busy,
  output logic                   done
);
  lut_ld_state_e          r_state;
  logic                   r_we;
  logic                   r_busy;
  logic                   r_done;
  logic [QUAN_SIZE-1:0]   r_bank0;
  logic [QUAN_SIZE-1:0]   r_bank1;
  logic [PAGE_ADDR_W-1:0] r_page;
  logic                   r_off;

  logic                   w_load;
  logic                   w_accept;
  logic [ADDR_W-1:0]      w_addr;
  logic                   w_last;
  entry_pair_t            w_pair;

  assign w_pair   = entry_pair_t'(in_data);
  assign w_load   = (r_state == IDLE) && start;
  assign w_accept = (r_state == LOAD) && in_valid;

  sym_vn_lut_addr_cnt u_cnt (
    .clk          (write_clk),
    .rst          (rst),
    .i_load       (w_load),
    .i_start_addr (cfg_start_addr),
    .i_len        (cfg_len),
    .i_inc        (w_accept),
    .o_addr       (w_addr),
    .o_last       (w_last)
  );

  // Load FSM with registered write transaction and status outputs.
  always_ff @(posedge write_clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_we    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_bank0 <= '0;
      r_bank1 <= '0;
      r_page  <= '0;
      r_off   <= 1'b0;
    end else begin
      r_we   <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_busy <= 1'b1;
            if (sat_len(cfg_len) == '0) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= LOAD;
            end
          end
        end
        LOAD: begin
          if (w_accept) begin
            r_we    <= 1'b1;
            r_bank0 <= w_pair.bank0;
            r_bank1 <= w_pair.bank1;
            r_page  <= w_addr[PAGE_ADDR_W-1:0];
            r_off   <= w_addr[ADDR_W-1];
            if (w_last) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready          = (r_state == LOAD);
  assign we                = r_we;
  assign busy              = r_busy;
  assign done              = r_done;
  assign lut_in_bank0      = r_bank0;
  assign lut_in_bank1      = r_bank1;
  assign page_write_addr   = r_page;
  assign write_addr_offset = r_off;
endmodule

// File: tb/tb_sym_vn_lut_loader.sv
// Self-checking bench: randomized loads against a behavioural LUT-load model.
module tb_sym_vn_lut_loader;
  logic       clk = 1'b0;
  logic       rst, start, in_valid;
  logic [6:0] cfg_start_addr;
  logic [7:0] cfg_len, in_data;
  logic       in_ready, we, busy, done, write_addr_offset;
  logic [3:0] lut_in_bank0, lut_in_bank1;
  logic [5:0] page_write_addr;

  always #5 clk = ~clk;

  sym_vn_lut_loader dut (
    .write_clk(clk), .rst(rst), .start(start), .cfg_start_addr(cfg_start_addr),
    .cfg_len(cfg_len), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .lut_in_bank0(lut_in_bank0), .lut_in_bank1(lut_in_bank1),
    .page_write_addr(page_write_addr), .write_addr_offset(write_addr_offset),
    .we(we), .busy(busy), .done(done)
  );

  int n_chk = 0, n_fail = 0;
  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: phase 0=idle,1=loading,2=finishing; plain integer address.
  int m_ph = 0, m_addr = 0, m_rem = 0;
  int e_we = 0, e_done = 0, e_busy = 0, e_b0 = 0, e_b1 = 0, e_waddr = 0;
  bit armed = 0;
  always @(posedge clk) begin
    if (rst) begin
      m_ph = 0; m_addr = 0; m_rem = 0;
      e_we = 0; e_done = 0; e_busy = 0; e_b0 = 0; e_b1 = 0; e_waddr = 0;
      armed = 1;
    end else begin
      e_we = 0; e_done = 0;
      if (m_ph == 0) begin
        if (start) begin
          m_rem  = (cfg_len > 128) ? 128 : int'(cfg_len);
          m_addr = int'(cfg_start_addr);
          e_busy = 1;
          if (m_rem == 0) begin m_ph = 2; e_done = 1; end
          else m_ph = 1;
        end
      end else if (m_ph == 1) begin
        if (in_valid) begin
          e_we = 1; e_b0 = in_data % 16; e_b1 = in_data / 16; e_waddr = m_addr;
          m_addr = (m_addr + 1) % 128;
          m_rem--;
          if (m_rem == 0) begin m_ph = 2; e_done = 1; end
        end
      end else begin
        m_ph = 0; e_busy = 0;
      end
    end
  end

  // DUT-side write log, used by the literal checks.
  int lut_seen [128];
  int we_cnt = 0, done_cnt = 0;
  always @(negedge clk) begin
    if (we) lut_seen[{write_addr_offset, page_write_addr}] = int'({lut_in_bank1, lut_in_bank0});
    if (we) we_cnt++;
    if (done) done_cnt++;
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (armed) begin
      chk("in_ready", int'(in_ready), (m_ph == 1) ? 1 : 0);
      chk("we", int'(we), e_we);
      chk("done", int'(done), e_done);
      chk("busy", int'(busy), e_busy);
      chk("bank0", int'(lut_in_bank0), e_b0);
      chk("bank1", int'(lut_in_bank1), e_b1);
      chk("waddr", int'({write_addr_offset, page_write_addr}), e_waddr);
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic pulse_start(input int a, input int l);
    start = 1; cfg_start_addr = 7'(a); cfg_len = 8'(l);
    step();
    start = 0;
  endtask

  task automatic beat(input bit v, input int d);
    in_valid = v; in_data = 8'(d);
    step();
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    in_valid = 0;
    while (m_ph != 0 && n < budget) begin step(); n++; end
    chk({name, "_timeout"}, (m_ph == 0) ? 1 : 0, 1);
  endtask

  int w0, d0;
  initial begin
    rst = 1; start = 0; in_valid = 0; in_data = 0; cfg_start_addr = 0; cfg_len = 0;
    step(); step();
    rst = 0;
    chk("rst_we", int'(we), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_waddr", int'(page_write_addr), 0);
    step();

    // Full 128-entry load.
    w0 = we_cnt; d0 = done_cnt;
    pulse_start(0, 128);
    for (int i = 0; i < 128; i++) beat(1, i);
    in_valid = 0;
    chk("full_done_now", int'(done), 1);
    step(); step();
    chk("full_we_cnt", we_cnt - w0, 128);
    chk("full_done_cnt", done_cnt - d0, 1);
    chk("full_lut64", lut_seen[64], 8'h40);
    chk("full_lut127", lut_seen[127], 8'h7F);
    chk("full_lut5", lut_seen[5], 8'h05);

    // Wrap across address 127 -> 0.
    w0 = we_cnt;
    pulse_start(126, 4);
    beat(1, 8'hA1); beat(1, 8'hB2); beat(1, 8'hC3); beat(1, 8'hD4);
    wait_idle(10, "wrap");
    chk("wrap_we_cnt", we_cnt - w0, 4);
    chk("wrap_126", lut_seen[126], 8'hA1);
    chk("wrap_127", lut_seen[127], 8'hB2);
    chk("wrap_0", lut_seen[0], 8'hC3);
    chk("wrap_1", lut_seen[1], 8'hD4);

    // Bubbles in the input stream, plus an ignored start mid-load.
    w0 = we_cnt;
    pulse_start(20, 3);
    beat(1, 8'h11);
    start = 1; cfg_start_addr = 7'd90; cfg_len = 8'd50;
    beat(0, 8'hEE);
    start = 0;
    beat(0, 8'hEE); beat(1, 8'h22); beat(1, 8'h33);
    wait_idle(10, "bubble");
    chk("bub_we_cnt", we_cnt - w0, 3);
    chk("bub_21", lut_seen[21], 8'h22);
    chk("bub_22", lut_seen[22], 8'h33);

    // Zero length: done with no writes.
    w0 = we_cnt; d0 = done_cnt;
    pulse_start(40, 0);
    chk("zero_done", int'(done), 1);
    wait_idle(5, "zero");
    step();
    chk("zero_we_cnt", we_cnt - w0, 0);
    chk("zero_done_cnt", done_cnt - d0, 1);

    // Reset mid-load, then a normal short load.
    w0 = we_cnt; d0 = done_cnt;
    pulse_start(60, 10);
    for (int i = 0; i < 5; i++) beat(1, 8'h50 + i);
    rst = 1; beat(1, 8'hFF); rst = 0;
    in_valid = 0;
    chk("mid_rst_ready", int'(in_ready), 0);
    step(); step();
    chk("mid_rst_we_cnt", we_cnt - w0, 5);
    chk("mid_rst_done_cnt", done_cnt - d0, 0);
    w0 = we_cnt;
    pulse_start(3, 2);
    beat(1, 8'h9C); beat(1, 8'h9D);
    wait_idle(10, "after_rst");
    chk("after_rst_we_cnt", we_cnt - w0, 2);
    chk("after_rst_4", lut_seen[4], 8'h9D);

    // Randomized loads with random bubbles, stray starts and rare resets.
    for (int k = 0; k < 40; k++) begin
      int r, len, n;
      r = $urandom_range(0, 7);
      len = (r == 0) ? 0 : (r == 1) ? $urandom_range(129, 255) : $urandom_range(1, 40);
      pulse_start($urandom_range(0, 127), len);
      n = 0;
      while (m_ph != 0 && n < 1200) begin
        start = ($urandom_range(0, 9) == 0);
        cfg_start_addr = 7'($urandom); cfg_len = 8'($urandom);
        rst = ($urandom_range(0, 299) == 0);
        in_valid = ($urandom_range(0, 3) != 0);
        in_data = 8'($urandom);
        step(); n++;
      end
      start = 0; rst = 0; in_valid = 0;
      chk("rand_timeout", (m_ph == 0) ? 1 : 0, 1);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
